inv_round_key_mix: RTL
======================

Name: inv_round_key_mix

Overview:
Decryption-round back end that consumes the 128-bit state produced by the inverse S-box stage. It performs AddRoundKey (XOR with the round key) and then InvMixColumns, one or more 32-bit columns per cycle. A skip_mix flag bypasses InvMixColumns for the final decryption round. Valid/ready handshakes on both sides let the round controller stall and launch rounds.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values are 1, 2 or 4. Any other value is a synthesis-time error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  state_in, round_key and skip_mix are valid
in_ready  output  1  block can accept a new state
state_in  input  128  state from inverse S-box stage. Bits [127:120] are byte 0 (row 0, col 0). Column c occupies bits [127-32c : 96-32c].
round_key  input  128  round key, same byte order as state_in
skip_mix  input  1  1 = AddRoundKey only (final round)
out_valid  output  1  state_out holds a result
out_ready  input  1  consumer accepts the result
state_out  output  128  result, same byte order
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (rst high at a clk edge):
  - FSM goes to IDLE, column counter = 0.
  - Work register = 0, so state_out = 0; out_valid = 0.
  - in_ready = 0 while rst is high and 1 in IDLE afterwards.
  - Reset mid-operation aborts the transform with no output.
- FSM states: IDLE, BUSY, DONE. in_ready = (FSM==IDLE) && !rst.
- IDLE:
  - On an edge with in_valid && in_ready, the work register loads state_in XOR round_key and skip_mix is latched.
  - If skip_mix = 1, next state is DONE. If skip_mix = 0, next state is BUSY with the counter at 0.
- BUSY:
  - Each edge replaces columns counter .. counter+COLS_PER_CYCLE-1 with their InvMixColumns result.
  - Column 0 is processed first. The counter advances by COLS_PER_CYCLE.
  - After column 3 is written, next state is DONE and the counter returns to 0.
  - Inputs are ignored while BUSY.
- DONE:
  - out_valid = 1 and state_out = work register.
  - Both hold stable until out_ready is high.
  - On an edge with out_ready high, next state is IDLE and out_valid drops.
  - A new input is accepted at the earliest one cycle after the output handshake; accepting and emitting in the same cycle is not allowed.
- Latency from accept edge to first out_valid cycle:
  - skip_mix = 0: 4/COLS_PER_CYCLE + 1 edges, i.e. 5 edges for COLS_PER_CYCLE = 1.
  - skip_mix = 1: 1 edge.
- InvMixColumns, per column (a0, a1, a2, a3), top byte = a0:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3, with the coefficients rotated for each b_i (circulant matrix).
  - GF(2^8) multiplication uses xtime chains with reduction polynomial 0x11B, and 8-bit results throughout.
  - Combinational logic feeds the register; no extra pipeline stages are inserted.
- state_out is driven directly from the work register, never combinationally from the inputs.
- out_ready high outside DONE has no effect. in_valid while not IDLE is ignored, so upstream must hold its data.

Test Plan:
- Pure InvMixColumns, COLS_PER_CYCLE=1:
  - Stimulus: state_in = 8e4da1bc_9fdc589d_01010101_d5d5d7d6, round_key = 0, skip_mix = 0, out_ready = 1.
  - Required: state_out = db135345_f20a225c_01010101_d4d4d4d5, out_valid high exactly 5 edges after the accept edge, for one cycle.
- AddRoundKey only:
  - Stimulus: state_in = 00112233_44556677_8899aabb_ccddeeff, round_key = ffffffff_ffffffff_ffffffff_ffffffff, skip_mix = 1.
  - Required: state_out = ffeeddcc_bbaa9988_77665544_33221100, out_valid 1 edge after accept.
- Combined AddRoundKey + InvMixColumns:
  - Stimulus: state_in = 8e4da1bd_..., round_key = 00000001_00..00 (key cancels the low-byte difference in column 0).
  - Required: column 0 result = db135345.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles in DONE.
  - Required: out_valid and state_out stable, in_ready = 0, a new in_valid ignored. Release out_ready; IDLE follows and in_ready rises the next cycle.
- Reset mid-BUSY:
  - Stimulus: assert rst at the 2nd BUSY edge.
  - Required: next cycle out_valid = 0 and state_out = 0; FSM returns to IDLE and in_ready = 1 after rst deasserts; no stale output afterwards.
- Parameter sweep:
  - Stimulus: repeat the first scenario with COLS_PER_CYCLE = 2 and 4.
  - Required: identical state_out, latency 3 and 2 edges respectively.

Source files
------------

// File: rtl/inv_round_key_mix_if.sv
// Handshake bundle for the decryption-round back end: upstream state/key/skip and downstream result.
// master drives the request side and out_ready; slave is the transform block.
interface inv_round_key_mix_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         skip_mix;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output in_valid, state_in, round_key, skip_mix, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, round_key, skip_mix, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/inv_round_key_mix.sv
// AddRoundKey then InvMixColumns, COLS_PER_CYCLE columns per edge; result after 4/COLS_PER_CYCLE+1 edges (1 with skip_mix).
// Result holds in DONE until out_ready; new input is accepted only in IDLE, the cycle after the output handshake.
module inv_round_key_mix #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  inv_round_key_mix_if.slave  bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("inv_round_key_mix: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [2:0] STEP   = 3'(COLS_PER_CYCLE);

  logic [1:0]   r_state;
  logic [1:0]   r_col;
  logic [127:0] r_work;

  logic [31:0]  w_mixed [4];
  logic [127:0] w_next_work;
  logic [2:0]   w_col_next;
  logic         w_last;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // Column bytes are a0 (top, bits 31:24) .. a3; circulant 0e 0b 0d 09.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign w_mixed[c] = inv_mix_col(r_work[127-32*c -: 32]);
  end

  assign w_col_next = {1'b0, r_col} + STEP;
  assign w_last     = (w_col_next == 3'd4);

  // Only the columns in the current window are replaced; the rest pass through.
  always_comb begin
    w_next_work = r_work;
    for (int c = 0; c < 4; c++) begin
      if (c >= int'(r_col) && c < int'(r_col) + COLS_PER_CYCLE) begin
        w_next_work[127-32*c -: 32] = w_mixed[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= 2'd0;
      r_work  <= 128'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_work  <= bus.state_in ^ bus.round_key;
            r_col   <= 2'd0;
            r_state <= bus.skip_mix ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          r_work <= w_next_work;
          if (w_last) begin
            r_col   <= 2'd0;
            r_state <= S_DONE;
          end else begin
            r_col   <= w_col_next[1:0];
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.state_out = r_work;
  assign bus.busy      = (r_state == S_BUSY) || (r_state == S_DONE);

endmodule
